// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: state encoding, oversampling factor
// and the clock-divider calculation.
package uart_pkg;

    localparam int UART_OVS = 16;
    localparam int DATA_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
        return (clk_freq + (baud * ovs) / 2) / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Receiver-side signal bundle: serial line in, parallel byte and status out.
interface uart_rx_engine_if;
    import uart_pkg::*;

    logic              uart_rx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_end;
    logic              rx_status;
    logic              frame_err;

    modport master (
        input  uart_rx,
        output rx_data,
        output rx_end,
        output rx_status,
        output frame_err
    );

    modport slave (
        output uart_rx,
        input  rx_data,
        input  rx_end,
        input  rx_status,
        input  frame_err
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; a clear re-phases it to a line event.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = calc_div(100_000_000, 9600, UART_OVS)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_engine.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and false-start
// rejection; emits the byte with a one-cycle rx_end or frame_err pulse.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = UART_OVS,
    parameter int DIV      = calc_div(CLK_FREQ, BAUD, OVS)
) (
    input  logic              clk,
    input  logic              reset,
    uart_rx_engine_if.master  bus
);

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic [3:0]        sc_q, sc_d;
    logic [2:0]        bi_q, bi_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_end_q, rx_end_d;
    logic              frame_err_q, frame_err_d;
    logic              fall;
    logic              tick;
    logic              tick_clear;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    assign fall = ~sync2_q & prev_q;

    always_comb begin
        sync1_d     = bus.uart_rx;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        state_d     = state_q;
        sc_d        = sc_q;
        bi_d        = bi_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_end_d    = 1'b0;
        frame_err_d = 1'b0;
        tick_clear  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    sc_d       = 4'd0;
                    tick_clear = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (sc_q == 4'd7) begin
                        sc_d    = 4'd0;
                        bi_d    = 3'd0;
                        state_d = sync2_q ? IDLE : DATA;
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sc_q == 4'd15) begin
                        sc_d    = 4'd0;
                        shift_d = {sync2_q, shift_q[DATA_W-1:1]};
                        if (bi_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bi_d = bi_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sc_q == 4'd15) begin
                        sc_d    = 4'd0;
                        state_d = IDLE;
                        if (sync2_q) begin
                            rx_data_d = shift_q;
                            rx_end_d  = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        // Hold the edge flop so a start edge landing on this
                        // exact cycle is still seen from IDLE next cycle.
                        if (fall) begin
                            prev_d = prev_q;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            sc_q        <= 4'd0;
            bi_q        <= 3'd0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_end_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            sc_q        <= sc_d;
            bi_q        <= bi_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_end_q    <= rx_end_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_end    = rx_end_q;
    assign bus.rx_status = (state_q != IDLE);
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine at DIV=10 (160 clk per bit).
module tb_uart_rx_engine;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CLKS = 160;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] end_data[$];
    int         end_cyc[$];
    int         fe_count = 0;
    int         conflict_count = 0;
    logic       prev_pulse = 1'b0;

    uart_rx_engine_if bus();

    uart_rx_engine #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every completion and framing-error pulse.
    always @(negedge clk) begin
        if (bus.rx_end === 1'b1) begin
            end_data.push_back(bus.rx_data);
            end_cyc.push_back(cyc);
        end
        if (bus.frame_err === 1'b1) fe_count++;
        if ((bus.rx_end === 1'b1 && bus.frame_err === 1'b1) ||
            (prev_pulse && (bus.rx_end === 1'b1 || bus.frame_err === 1'b1)))
            conflict_count++;
        prev_pulse = (bus.rx_end === 1'b1) || (bus.frame_err === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bits(input logic b, input int n);
        bus.uart_rx = b;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        drive_bits(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bits(data[i], BIT_CLKS);
        drive_bits(stop_bit, BIT_CLKS);
    endtask

    task automatic clear_monitor();
        end_data.delete();
        end_cyc.delete();
        fe_count = 0;
    endtask

    task automatic test_reset();
        bus.uart_rx = 1'b1;
        reset = 1'b1;
        tick(4);
        checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %0h expected 00", bus.rx_data); end
        checks++; if (bus.rx_end !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_end: got %0b expected 0", bus.rx_end); end
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_status: got %0b expected 0", bus.rx_status); end
        checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %0b expected 0", bus.frame_err); end
        reset = 1'b0;
        tick(20);
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL idle_rx_status: got %0b expected 0", bus.rx_status); end
    endtask

    task automatic test_basic_frame();
        int c;
        int lows;
        clear_monitor();
        c = cyc;
        lows = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(5);
                repeat (1500) begin
                    if (bus.rx_status !== 1'b1) lows++;
                    tick(1);
                end
            end
        join
        tick(20);
        checks++; if (end_data.size() != 1) begin failures++; $display("[TB] FAIL a5_pulse_count: got %0d expected 1", end_data.size()); end
        if (end_data.size() >= 1) begin
            checks++; if (end_data[0] !== 8'hA5) begin failures++; $display("[TB] FAIL a5_data: got %0h expected a5", end_data[0]); end
            checks++; if ((end_cyc[0] - c) < 1512 || (end_cyc[0] - c) > 1532) begin failures++; $display("[TB] FAIL a5_latency: got %0d expected 1522+-10", end_cyc[0] - c); end
        end
        checks++; if (fe_count != 0) begin failures++; $display("[TB] FAIL a5_frame_err: got %0d expected 0", fe_count); end
        checks++; if (lows != 0) begin failures++; $display("[TB] FAIL a5_status_low_cycles: got %0d expected 0", lows); end
        checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL a5_rx_data_held: got %0h expected a5", bus.rx_data); end
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL a5_status_after: got %0b expected 0", bus.rx_status); end
    endtask

    task automatic test_glitch();
        clear_monitor();
        bus.uart_rx = 1'b0;
        tick(10);
        checks++; if (bus.rx_status !== 1'b1) begin failures++; $display("[TB] FAIL glitch_status_rise: got %0b expected 1", bus.rx_status); end
        tick(40);
        bus.uart_rx = 1'b1;
        tick(50);
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL glitch_status_fall: got %0b expected 0", bus.rx_status); end
        tick(300);
        checks++; if (end_data.size() != 0) begin failures++; $display("[TB] FAIL glitch_rx_end: got %0d expected 0", end_data.size()); end
        checks++; if (fe_count != 0) begin failures++; $display("[TB] FAIL glitch_frame_err: got %0d expected 0", fe_count); end
        checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL glitch_rx_data: got %0h expected a5", bus.rx_data); end
    endtask

    task automatic test_frame_error();
        clear_monitor();
        send_frame(8'h3C, 1'b0);
        bus.uart_rx = 1'b1;
        tick(BIT_CLKS);
        checks++; if (fe_count != 1) begin failures++; $display("[TB] FAIL ferr_count: got %0d expected 1", fe_count); end
        checks++; if (end_data.size() != 0) begin failures++; $display("[TB] FAIL ferr_rx_end: got %0d expected 0", end_data.size()); end
        checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL ferr_rx_data: got %0h expected a5", bus.rx_data); end
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL ferr_status: got %0b expected 0", bus.rx_status); end
    endtask

    task automatic test_back_to_back();
        clear_monitor();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(40);
        checks++; if (end_data.size() != 2) begin failures++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 2", end_data.size()); end
        if (end_data.size() >= 2) begin
            checks++; if (end_data[0] !== 8'h00) begin failures++; $display("[TB] FAIL b2b_first_data: got %0h expected 00", end_data[0]); end
            checks++; if (end_data[1] !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_second_data: got %0h expected ff", end_data[1]); end
            checks++; if (end_cyc[1] - end_cyc[0] != 1600) begin failures++; $display("[TB] FAIL b2b_spacing: got %0d expected 1600", end_cyc[1] - end_cyc[0]); end
        end
        checks++; if (fe_count != 0) begin failures++; $display("[TB] FAIL b2b_frame_err: got %0d expected 0", fe_count); end
    endtask

    task automatic test_reset_midframe();
        clear_monitor();
        // 8'h81 up to the middle of data bit 3; the link partner is reset too.
        drive_bits(1'b0, BIT_CLKS);
        drive_bits(1'b1, BIT_CLKS);
        drive_bits(1'b0, BIT_CLKS);
        drive_bits(1'b0, BIT_CLKS);
        drive_bits(1'b0, BIT_CLKS / 2);
        checks++; if (bus.rx_status !== 1'b1) begin failures++; $display("[TB] FAIL mid_status_busy: got %0b expected 1", bus.rx_status); end
        reset = 1'b1;
        bus.uart_rx = 1'b1;
        tick(1);
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_status: got %0b expected 0", bus.rx_status); end
        checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("[TB] FAIL mid_reset_rx_data: got %0h expected 00", bus.rx_data); end
        tick(2);
        reset = 1'b0;
        tick(1700);
        checks++; if (end_data.size() != 0) begin failures++; $display("[TB] FAIL mid_no_rx_end: got %0d expected 0", end_data.size()); end
        checks++; if (fe_count != 0) begin failures++; $display("[TB] FAIL mid_no_frame_err: got %0d expected 0", fe_count); end
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL mid_status_idle: got %0b expected 0", bus.rx_status); end
        send_frame(8'h42, 1'b1);
        tick(40);
        checks++; if (end_data.size() != 1) begin failures++; $display("[TB] FAIL mid_next_count: got %0d expected 1", end_data.size()); end
        if (end_data.size() >= 1) begin
            checks++; if (end_data[0] !== 8'h42) begin failures++; $display("[TB] FAIL mid_next_data: got %0h expected 42", end_data[0]); end
        end
    endtask

    task automatic test_break();
        clear_monitor();
        bus.uart_rx = 1'b0;
        tick(30 * BIT_CLKS);
        bus.uart_rx = 1'b1;
        tick(200);
        checks++; if (fe_count != 1) begin failures++; $display("[TB] FAIL break_frame_err: got %0d expected 1", fe_count); end
        checks++; if (end_data.size() != 0) begin failures++; $display("[TB] FAIL break_rx_end: got %0d expected 0", end_data.size()); end
        checks++; if (bus.rx_status !== 1'b0) begin failures++; $display("[TB] FAIL break_status: got %0b expected 0", bus.rx_status); end
        checks++; if (bus.rx_data !== 8'h42) begin failures++; $display("[TB] FAIL break_rx_data: got %0h expected 42", bus.rx_data); end
        clear_monitor();
        send_frame(8'h55, 1'b1);
        tick(40);
        checks++; if (end_data.size() != 1) begin failures++; $display("[TB] FAIL break_next_count: got %0d expected 1", end_data.size()); end
        if (end_data.size() >= 1) begin
            checks++; if (end_data[0] !== 8'h55) begin failures++; $display("[TB] FAIL break_next_data: got %0h expected 55", end_data[0]); end
        end
        checks++; if (fe_count != 0) begin failures++; $display("[TB] FAIL break_next_frame_err: got %0d expected 0", fe_count); end
    endtask

    initial begin
        bus.uart_rx = 1'b1;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_break();
        checks++; if (conflict_count != 0) begin failures++; $display("[TB] FAIL pulse_exclusive: got %0d overlaps expected 0", conflict_count); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
